// File: rtl/mem_pkg.sv
// Shared types and encodings for the M-stage data-memory interface.
package mem_pkg;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    localparam logic [1:0] MW_NONE = 2'b00;
    localparam logic [1:0] MW_WORD = 2'b01;
    localparam logic [1:0] MW_HALF = 2'b10;
    localparam logic [1:0] MW_BYTE = 2'b11;

    localparam logic [2:0] RT_LW  = 3'b000;
    localparam logic [2:0] RT_LH  = 3'b001;
    localparam logic [2:0] RT_LHU = 3'b010;
    localparam logic [2:0] RT_LB  = 3'b011;
    localparam logic [2:0] RT_LBU = 3'b100;

endpackage

// File: rtl/mem_access_unit_load_align.sv
// Load data aligner: selects the addressed byte/half of a memory word and
// sign- or zero-extends it; unknown load types pass the word through.
module load_align
    import mem_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  addr,
    input  logic [2:0]  readtype,
    output logic [31:0] data
);

    logic [7:0]  selByte;
    logic [15:0] selHalf;

    always_comb begin
        case (addr)
            2'd0:    selByte = rdata[7:0];
            2'd1:    selByte = rdata[15:8];
            2'd2:    selByte = rdata[23:16];
            default: selByte = rdata[31:24];
        endcase
        selHalf = addr[1] ? rdata[31:16] : rdata[15:0];

        case (readtype)
            RT_LH:   data = {{16{selHalf[15]}}, selHalf};
            RT_LHU:  data = {16'h0000, selHalf};
            RT_LB:   data = {{24{selByte[7]}}, selByte};
            RT_LBU:  data = {24'h000000, selByte};
            default: data = rdata;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// M-stage data-memory interface: req/ready handshake, store lane builder,
// load alignment. Optional misalignment trap under MEM_MISALIGN_EXC_EN.
module mem_access_unit
    import mem_pkg::*;
#(
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          readreqM,
    input  logic [1:0]    memwriteM,
    input  logic [2:0]    readtypeM,
    input  logic [AW-1:0] addrM,
    input  logic [DW-1:0] writedataM,
    input  logic          mem_ready,
    input  logic [DW-1:0] mem_rdata,
    output logic          mem_req,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [3:0]    mem_be,
    output logic [DW-1:0] mem_wdata,
    output logic [DW-1:0] readdataM,
`ifdef MEM_MISALIGN_EXC_EN
    output logic          misalignM,
`endif
    output logic          stallM
);

    state_t        state;
    logic          isStore;
    logic          access;
    logic          misaligned;
    logic          go;
    logic [3:0]    beNext;
    logic [DW-1:0] wdataNext;
    logic [1:0]    addrLo;
    logic [2:0]    rtype;
    logic [DW-1:0] loadData;

    assign isStore = (memwriteM != MW_NONE);
    assign access  = readreqM | isStore;

`ifdef MEM_MISALIGN_EXC_EN
    always_comb begin
        misaligned = 1'b0;
        if (isStore) begin
            misaligned = ((memwriteM == MW_WORD) && (addrM[1:0] != 2'b00)) ||
                         ((memwriteM == MW_HALF) && addrM[0]);
        end else if (readreqM) begin
            case (readtypeM)
                RT_LH, RT_LHU: misaligned = addrM[0];
                RT_LB, RT_LBU: misaligned = 1'b0;
                default:       misaligned = (addrM[1:0] != 2'b00);
            endcase
        end
    end
`else
    assign misaligned = 1'b0;
`endif

    assign go = access & ~misaligned;

    // Stall is raised combinationally in the detect cycle so the access
    // instruction is held in M while the request is outstanding.
    assign stallM = ~reset & ((state == BUSY) | ((state == IDLE) & go));

    always_comb begin
        beNext    = 4'b1111;
        wdataNext = writedataM;
        case (memwriteM)
            MW_HALF: begin
                beNext    = 4'b0011 << {addrM[1], 1'b0};
                wdataNext = {2{writedataM[15:0]}};
            end
            MW_BYTE: begin
                beNext    = 4'b0001 << addrM[1:0];
                wdataNext = {4{writedataM[7:0]}};
            end
            default: ;
        endcase
    end

    load_align uAlign (
        .rdata    (mem_rdata),
        .addr     (addrLo),
        .readtype (rtype),
        .data     (loadData)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_be    <= '0;
            mem_wdata <= '0;
            readdataM <= '0;
            addrLo    <= '0;
            rtype     <= RT_LW;
`ifdef MEM_MISALIGN_EXC_EN
            misalignM <= 1'b0;
`endif
        end else begin
`ifdef MEM_MISALIGN_EXC_EN
            misalignM <= 1'b0;
`endif
            case (state)
                IDLE: begin
`ifdef MEM_MISALIGN_EXC_EN
                    misalignM <= access & misaligned;
`endif
                    if (go) begin
                        mem_req   <= 1'b1;
                        mem_we    <= isStore;
                        mem_addr  <= {addrM[AW-1:2], 2'b00};
                        mem_be    <= beNext;
                        mem_wdata <= wdataNext;
                        addrLo    <= addrM[1:0];
                        rtype     <= readtypeM;
                        state     <= BUSY;
                    end
                end
                BUSY: begin
                    if (mem_ready) begin
                        mem_req <= 1'b0;
                        if (!mem_we) readdataM <= loadData;
                        state <= DONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: directed vector table, corner
// sequences and randomized accesses against an arithmetic reference model.
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        readreqM;
    logic [1:0]  memwriteM;
    logic [2:0]  readtypeM;
    logic [31:0] addrM;
    logic [31:0] writedataM;
    logic        mem_ready;
    logic [31:0] mem_rdata;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic [31:0] readdataM;
    logic        stallM;
`ifdef MEM_MISALIGN_EXC_EN
    logic        misalignM;
`endif

    int checks   = 0;
    int failures = 0;
    bit [31:0] lastRd = 32'h0;

    always #5 clk = ~clk;

    mem_access_unit #(.AW(32), .DW(32)) dut (
        .clk        (clk),
        .reset      (reset),
        .readreqM   (readreqM),
        .memwriteM  (memwriteM),
        .readtypeM  (readtypeM),
        .addrM      (addrM),
        .writedataM (writedataM),
        .mem_ready  (mem_ready),
        .mem_rdata  (mem_rdata),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_be     (mem_be),
        .mem_wdata  (mem_wdata),
        .readdataM  (readdataM),
`ifdef MEM_MISALIGN_EXC_EN
        .misalignM  (misalignM),
`endif
        .stallM     (stallM)
    );

    typedef struct {
        bit        rr;
        bit [1:0]  mw;
        bit [2:0]  rt;
        bit [31:0] addr;
        bit [31:0] wd;
        bit [31:0] rd;
        int        waits;
        bit [3:0]  expBe;
        bit [31:0] expWd;
        bit [31:0] expRd;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: lane arithmetic straight from the access-size rules.
    function automatic bit [31:0] modelLoad(bit [2:0] rt, bit [1:0] lo, bit [31:0] rd);
        int unsigned sh;
        bit [31:0] mask, v;
        bit sgn;
        case (rt)
            3'd1, 3'd2: begin sh = (lo & 2'd2) * 8; mask = 32'hFFFF; sgn = (rt == 3'd1); end
            3'd3, 3'd4: begin sh = lo * 8;          mask = 32'hFF;   sgn = (rt == 3'd3); end
            default: return rd;
        endcase
        v = (rd >> sh) & mask;
        if (sgn && ((v & ((mask + 1) >> 1)) != 0)) v = v | ~mask;
        return v;
    endfunction

    function automatic bit [3:0] modelBe(bit [1:0] mw, bit [31:0] a);
        case (mw)
            2'd2:    return 4'(3 << (a & 2));
            2'd3:    return 4'(1 << (a & 3));
            default: return 4'hF;
        endcase
    endfunction

    function automatic bit [31:0] modelWd(bit [1:0] mw, bit [31:0] wd);
        case (mw)
            2'd2:    return (wd & 32'hFFFF) * 32'h0001_0001;
            2'd3:    return (wd & 32'hFF) * 32'h0101_0101;
            default: return wd;
        endcase
    endfunction

    // Entered just after a posedge with the DUT in IDLE; leaves just after
    // the posedge that ends the DONE cycle.
    task automatic doAccess(input bit rr, input bit [1:0] mw, input bit [2:0] rt,
                            input bit [31:0] a, input bit [31:0] wd, input bit [31:0] rd,
                            input int waits, input bit [3:0] eBe, input bit [31:0] eWd,
                            input bit [31:0] eRd);
        int stalls = 0;
        readreqM = rr; memwriteM = mw; readtypeM = rt; addrM = a; writedataM = wd;
        @(negedge clk);
        if (stallM) stalls++;
        chk("detect_req", mem_req, 0);
        @(posedge clk); #1;
        for (int w = 0; w <= waits; w++) begin
            mem_ready = (w == waits);
            mem_rdata = (w == waits) ? rd : $urandom;
            @(negedge clk);
            if (stallM) stalls++;
            chk("busy_req", mem_req, 1);
            chk("busy_we", mem_we, (mw != 2'd0));
            chk("busy_addr", mem_addr, a & 32'hFFFF_FFFC);
            chk("busy_be", mem_be, eBe);
            if (mw != 2'd0) chk("busy_wdata", mem_wdata, eWd);
            @(posedge clk); #1;
        end
        mem_ready = 1'b0;
        mem_rdata = $urandom;
        @(negedge clk);
        chk("done_stall", stallM, 0);
        chk("done_req", mem_req, 0);
        chk("done_rdata", readdataM, eRd);
        chk("stall_cycles", stalls, waits + 2);
        @(posedge clk); #1;
        readreqM = 1'b0; memwriteM = 2'd0;
    endtask

    task automatic idleCycle();
        @(negedge clk);
        chk("idle_stall", stallM, 0);
        chk("idle_req", mem_req, 0);
        chk("idle_rdata", readdataM, lastRd);
        @(posedge clk); #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "timeout");
    end

    initial begin
        vec_t vecs[11];
        vecs[0]  = '{0, 2'd1, 3'd0, 32'h100, 32'hDEADBEEF, 32'h0,        1, 4'hF, 32'hDEADBEEF, 32'h0};
        vecs[1]  = '{1, 2'd0, 3'd3, 32'h203, 32'h0,        32'h80FF1234, 0, 4'hF, 32'h0,        32'hFFFFFF80};
        vecs[2]  = '{1, 2'd0, 3'd4, 32'h203, 32'h0,        32'h80FF1234, 0, 4'hF, 32'h0,        32'h00000080};
        vecs[3]  = '{1, 2'd0, 3'd1, 32'h202, 32'h0,        32'h80FF1234, 2, 4'hF, 32'h0,        32'hFFFF80FF};
        vecs[4]  = '{1, 2'd0, 3'd2, 32'h202, 32'h0,        32'h80FF1234, 0, 4'hF, 32'h0,        32'h000080FF};
        vecs[5]  = '{0, 2'd3, 3'd0, 32'h31,  32'h000000AB, 32'h0,        0, 4'h2, 32'hABABABAB, 32'h000080FF};
        vecs[6]  = '{0, 2'd2, 3'd0, 32'h42,  32'h1234CAFE, 32'h0,        1, 4'hC, 32'hCAFECAFE, 32'h000080FF};
        vecs[7]  = '{1, 2'd1, 3'd0, 32'h50,  32'h11223344, 32'h55555555, 0, 4'hF, 32'h11223344, 32'h000080FF};
        vecs[8]  = '{1, 2'd0, 3'd7, 32'h60,  32'h0,        32'h12345678, 3, 4'hF, 32'h0,        32'h12345678};
        vecs[9]  = '{1, 2'd0, 3'd3, 32'h61,  32'h0,        32'h12345678, 0, 4'hF, 32'h0,        32'h00000056};
        vecs[10] = '{1, 2'd0, 3'd1, 32'h200, 32'h0,        32'h12348001, 1, 4'hF, 32'h0,        32'hFFFF8001};

        reset = 1'b1; readreqM = 1'b0; memwriteM = 2'd0; readtypeM = 3'd0;
        addrM = '0; writedataM = '0; mem_ready = 1'b0; mem_rdata = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_req", mem_req, 0);
        chk("rst_stall", stallM, 0);
        chk("rst_rdata", readdataM, 0);
        chk("rst_be", mem_be, 0);
        chk("rst_addr", mem_addr, 0);
        @(posedge clk); #1;
        reset = 1'b0;

        foreach (vecs[i])
            doAccess(vecs[i].rr, vecs[i].mw, vecs[i].rt, vecs[i].addr, vecs[i].wd,
                     vecs[i].rd, vecs[i].waits, vecs[i].expBe, vecs[i].expWd, vecs[i].expRd);
        lastRd = 32'hFFFF8001;
        idleCycle();

`ifndef MEM_MISALIGN_EXC_EN
        // Conflicting low address bits are ignored by word/half accesses.
        doAccess(0, 2'd1, 3'd0, 32'h103, 32'hA5A5A5A5, 32'h0, 0, 4'hF, 32'hA5A5A5A5, lastRd);
        doAccess(1, 2'd0, 3'd1, 32'h203, 32'h0, 32'h7FFF0000, 0, 4'hF, 32'h0, 32'h00007FFF);
        lastRd = 32'h00007FFF;
`else
        readreqM = 1'b1; readtypeM = 3'd0; addrM = 32'h102;
        @(negedge clk);
        chk("mis_stall", stallM, 0);
        chk("mis_req", mem_req, 0);
        @(posedge clk); #1;
        readreqM = 1'b0;
        @(negedge clk);
        chk("mis_pulse", misalignM, 1);
        chk("mis_req2", mem_req, 0);
        chk("mis_rdata", readdataM, lastRd);
        @(posedge clk); #1;
        @(negedge clk);
        chk("mis_pulse_end", misalignM, 0);
        @(posedge clk); #1;
`endif

        // Reset while BUSY with no ready, then a stray ready must be ignored.
        readreqM = 1'b1; readtypeM = 3'd0; addrM = 32'h80;
        @(posedge clk); #1;
        reset = 1'b1;
        @(negedge clk);
        chk("rstbusy_stall_during", stallM, 0);
        @(posedge clk); #1;
        reset = 1'b0; readreqM = 1'b0;
        @(negedge clk);
        chk("rstbusy_req", mem_req, 0);
        chk("rstbusy_stall", stallM, 0);
        chk("rstbusy_rdata", readdataM, 0);
        @(posedge clk); #1;
        mem_ready = 1'b1; mem_rdata = 32'hCAFEF00D;
        @(posedge clk); #1;
        mem_ready = 1'b0;
        lastRd = 32'h0;
        idleCycle();
        doAccess(1, 2'd0, 3'd0, 32'h84, 32'h0, 32'h0BADBEEF, 1, 4'hF, 32'h0, 32'h0BADBEEF);
        lastRd = 32'h0BADBEEF;

        for (int n = 0; n < 40; n++) begin
            bit [1:0]  mw = 2'($urandom_range(0, 3));
            bit        rr = (mw == 2'd0) ? 1'b1 : 1'($urandom_range(0, 1));
            bit [2:0]  rt = 3'($urandom_range(0, 7));
            bit [31:0] a  = $urandom;
            bit [31:0] wd = $urandom;
            bit [31:0] rd = $urandom;
            int        wt = $urandom_range(0, 3);
`ifdef MEM_MISALIGN_EXC_EN
            if (mw == 2'd1 || (mw == 2'd0 && (rt == 3'd0 || rt > 3'd4))) a = a & ~32'h3;
            else if (mw == 2'd2 || (mw == 2'd0 && (rt == 3'd1 || rt == 3'd2))) a = a & ~32'h1;
`endif
            if (mw == 2'd0) lastRd = modelLoad(rt, a[1:0], rd);
            doAccess(rr, mw, rt, a, wd, rd, wt, modelBe(mw, a), modelWd(mw, wd), lastRd);
            for (int g = 0; g < int'($urandom_range(0, 2)); g++) idleCycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
